// File: rtl/glitch_filter_mc.sv
// Multi-channel glitch filter: optional two-flop synchroniser per channel, then
// bypass, symmetric debounce or pulse stretch, with registered rise/fall events.
module glitch_filter_mc #(
   parameter int CH      = 4,
   parameter int CNT_W   = 8,
   parameter bit SYNC_EN = 1'b1,
   parameter bit RST_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] filt_len,
   input  logic [CH-1:0]    din,
   output logic [CH-1:0]    dout,
   output logic [CH-1:0]    rise,
   output logic [CH-1:0]    fall
);

   typedef enum logic [1:0] {
      MODE_BYPASS   = 2'b00,
      MODE_DEBOUNCE = 2'b01,
      MODE_STRETCH  = 2'b10
   } fmode_e;

   localparam logic [CH-1:0]    RST_VEC = {CH{RST_VAL}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   WIDE_ONE = {{CNT_W{1'b0}}, 1'b1};

   logic [CH-1:0]    w_s;
   logic [1:0]       r_modeQ;
   logic             w_modeChg;
   fmode_e           w_mode;
   logic [CNT_W-1:0] w_len;
   logic [CNT_W-1:0] r_cnt     [CH];
   logic [CNT_W-1:0] w_cntNext [CH];
   logic [CH-1:0]    r_dout;
   logic [CH-1:0]    w_doutNext;
   logic [CH-1:0]    r_rise;
   logic [CH-1:0]    r_fall;

   generate
      if (SYNC_EN) begin : g_sync
         logic [CH-1:0] r_sync1;
         logic [CH-1:0] r_sync2;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sync1 <= RST_VEC;
               r_sync2 <= RST_VEC;
            end else begin
               r_sync1 <= din;
               r_sync2 <= r_sync1;
            end
         end

         assign w_s = r_sync2;
      end else begin : g_nosync
         assign w_s = din;
      end
   endgenerate

   always_comb begin
      w_mode = MODE_DEBOUNCE;
      if (mode == 2'b00) begin
         w_mode = MODE_BYPASS;
      end else if (mode == 2'b10) begin
         w_mode = MODE_STRETCH;
      end
   end

   assign w_modeChg = (mode != r_modeQ);
   assign w_len     = (filt_len == '0) ? CNT_ONE : filt_len;

   // A mode change clears every counter and freezes dout for that one cycle.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_doutNext[i] = r_dout[i];
         w_cntNext[i]  = r_cnt[i];
         if (w_modeChg) begin
            w_cntNext[i] = '0;
         end else begin
            case (w_mode)
               MODE_BYPASS: begin
                  w_doutNext[i] = w_s[i];
                  w_cntNext[i]  = '0;
               end
               MODE_STRETCH: begin
                  // Tail covers L full cycles after the cycle of the last high sample.
                  if (w_s[i]) begin
                     w_doutNext[i] = 1'b1;
                     w_cntNext[i]  = '0;
                  end else if (r_dout[i]) begin
                     if (r_cnt[i] >= w_len) begin
                        w_doutNext[i] = 1'b0;
                        w_cntNext[i]  = '0;
                     end else begin
                        w_cntNext[i] = (r_cnt[i] == CNT_MAX) ? CNT_MAX : r_cnt[i] + CNT_ONE;
                     end
                  end else begin
                     w_cntNext[i] = '0;
                  end
               end
               default: begin
                  if (w_s[i] == r_dout[i]) begin
                     w_cntNext[i] = '0;
                  end else if (({1'b0, r_cnt[i]} + WIDE_ONE) >= {1'b0, w_len}) begin
                     w_doutNext[i] = w_s[i];
                     w_cntNext[i]  = '0;
                  end else begin
                     w_cntNext[i] = (r_cnt[i] == CNT_MAX) ? CNT_MAX : r_cnt[i] + CNT_ONE;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_modeQ <= 2'b00;
         r_dout  <= RST_VEC;
         r_rise  <= '0;
         r_fall  <= '0;
         for (int i = 0; i < CH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_modeQ <= mode;
         r_dout  <= w_doutNext;
         r_rise  <= w_doutNext & ~r_dout;
         r_fall  <= ~w_doutNext & r_dout;
         for (int i = 0; i < CH; i++) begin
            r_cnt[i] <= w_cntNext[i];
         end
      end
   end

   assign dout = r_dout;
   assign rise = r_rise;
   assign fall = r_fall;

endmodule
